// File: rtl/bcd_pkg.sv
// Shared BCD datapath definitions: digit type, sequencer states and radix constants.
// The FIX state is only present when BCD_SUB_RECOMP_EN is defined.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;
  localparam int unsigned BCD_RADIX     = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
`ifdef BCD_SUB_RECOMP_EN
    FIX  = 2'd2,
`endif
    DONE = 2'd3
  } bcd_state_t;

  // True when the 4-bit code is a legal decimal digit.
  function automatic logic digit_valid(input bcd_digit_t d);
    return d <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

  // 9's complement of a legal digit.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_DIGIT_W'(BCD_MAX_DIGIT) - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction: sum = (x + y + cin) mod 10.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  localparam int unsigned SUM_W = 5;

  logic [SUM_W-1:0] raw;

  // Binary sum (max 19) folded back into 0..9 with a carry out.
  always_comb begin
    raw  = SUM_W'(x) + SUM_W'(y) + SUM_W'(cin);
    sum  = BCD_DIGIT_W'(raw);
    cout = 1'b0;
    if (raw > SUM_W'(BCD_MAX_DIGIT)) begin
      sum  = BCD_DIGIT_W'(raw - SUM_W'(BCD_RADIX));
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial N-digit BCD subtractor, A - B via 9's complement plus one,
// one digit per clock, least significant digit first.
// Optional macro BCD_SUB_RECOMP_EN: recomplement negative results to magnitude.
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] diff,
  output logic                  neg,
  output logic                  err
);

  localparam int unsigned W     = 4 * N_DIGITS;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  bcd_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             c;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;

  logic             operand_bad;
  logic             last_digit;
  bcd_digit_t       add_x;
  bcd_digit_t       add_y;
  bcd_digit_t       add_sum;
  logic             add_cout;

  // Flag any non-decimal digit in either incoming operand.
  always_comb begin
    operand_bad = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!digit_valid(a[4*i +: 4]) || !digit_valid(b[4*i +: 4])) begin
        operand_bad = 1'b1;
      end
    end
  end

  assign last_digit = (idx == IDX_W'(N_DIGITS - 1));

  // Select adder operands: subtract step, or recomplement of the stored result.
  always_comb begin
    add_x = a_sr[3:0];
    add_y = nines_comp(b_sr[3:0]);
`ifdef BCD_SUB_RECOMP_EN
    if (state == FIX) begin
      add_x = nines_comp(diff[3:0]);
      add_y = '0;
    end
`endif
  end

  bcd_digit_add u_digit_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (c),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Sequencer: capture, digit-serial subtract, optional recomplement, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      neg   <= 1'b0;
      err   <= 1'b0;
      c     <= 1'b0;
      idx   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            diff <= '0;
            neg  <= 1'b0;
            err  <= 1'b0;
            idx  <= '0;
            c    <= 1'b1;
            if (operand_bad) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= SUB;
            end
          end
        end

        SUB: begin
          diff <= (diff >> 4) | (W'(add_sum) << (W - 4));
          a_sr <= a_sr >> 4;
          b_sr <= b_sr >> 4;
          c    <= add_cout;
          if (last_digit) begin
            idx <= '0;
            if (add_cout) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              neg <= 1'b1;
`ifdef BCD_SUB_RECOMP_EN
              c     <= 1'b1;
              state <= FIX;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

`ifdef BCD_SUB_RECOMP_EN
        FIX: begin
          diff <= (diff >> 4) | (W'(add_sum) << (W - 4));
          c    <= add_cout;
          if (last_digit) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed, table-driven bench for bcd_sub_seq (N_DIGITS=4), follows BCD_SUB_RECOMP_EN.
module tb_bcd_sub_seq;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;
  localparam int MAX_WAIT = 40;

`ifdef BCD_SUB_RECOMP_EN
  localparam int NEG_LAT = 2 * N;
`else
  localparam int NEG_LAT = N;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
  logic         err;

  int tests;
  int fails;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_diff;
    logic         exp_neg;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[9];

  bcd_sub_seq #(.N_DIGITS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and check result, latency, busy and the one-cycle done pulse.
  // With poke set, a stray start with junk operands is driven while busy.
  task automatic run_op(input vec_t v, input bit poke);
    int k;
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    chk("busy_after_accept", 32'(busy), 32'(v.exp_lat > 0));
    while (!done && k < MAX_WAIT) begin
      if (poke && k == 1) begin
        a = 16'h1111;
        b = 16'h0000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
      if (!done && k < MAX_WAIT && busy !== 1'b1) begin
        chk("busy_mid_op", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'(v.exp_lat));
    chk("diff", 32'(diff), 32'(v.exp_diff));
    chk("neg", 32'(neg), 32'(v.exp_neg));
    chk("err", 32'(err), 32'(v.exp_err));
    chk("busy_in_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("diff_hold", 32'(diff), 32'(v.exp_diff));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

`ifdef BCD_SUB_RECOMP_EN
    vecs[0] = '{16'h0527, 16'h0198, 16'h0329, 1'b0, 1'b0, N};
    vecs[1] = '{16'h0198, 16'h0527, 16'h0329, 1'b1, 1'b0, NEG_LAT};
    vecs[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, NEG_LAT};
    vecs[3] = '{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, NEG_LAT};
`else
    vecs[0] = '{16'h0527, 16'h0198, 16'h0329, 1'b0, 1'b0, N};
    vecs[1] = '{16'h0198, 16'h0527, 16'h9671, 1'b1, 1'b0, NEG_LAT};
    vecs[2] = '{16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0, NEG_LAT};
    vecs[3] = '{16'h0001, 16'h0002, 16'h9999, 1'b1, 1'b0, NEG_LAT};
`endif
    vecs[4] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, N};
    vecs[5] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, N};
    vecs[6] = '{16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0, N};
    vecs[7] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0};
    vecs[8] = '{16'h0001, 16'h00F0, 16'h0000, 1'b0, 1'b1, 0};

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // Stray start while busy must not disturb the running operation.
    run_op(vecs[0], 1'b1);

    // Err result followed by a valid operation: err must clear on the next accept.
    run_op(vecs[7], 1'b0);
    run_op(vecs[6], 1'b0);

    // Start held through DONE is ignored until IDLE, then accepted.
    begin
      int k;
      @(negedge clk);
      a = 16'h0527;
      b = 16'h0198;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      while (!done && k < MAX_WAIT) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("held_first_lat", 32'(k), 32'(N));
      a = 16'h9999;
      b = 16'h0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("held_in_done_ignored", 32'(busy), 32'd0);
      chk("held_in_done_diff", 32'(diff), 32'h0329);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("held_accept_in_idle", 32'(busy), 32'd1);
      k = 0;
      while (!done && k < MAX_WAIT) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("held_second_lat", 32'(k), 32'(N));
      chk("held_second_diff", 32'(diff), 32'h9999);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset two cycles after accept.
    begin
      int seen_done;
      @(negedge clk);
      a = 16'h0527;
      b = 16'h0198;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_diff", 32'(diff), 32'd0);
      chk("mid_rst_neg", 32'(neg), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 2 * N + 2; i++) begin
        @(posedge clk);
        #1;
        if (done) seen_done++;
      end
      chk("no_done_after_rst", 32'(seen_done), 32'd0);
      chk("idle_after_rst", 32'(busy), 32'd0);
      run_op(vecs[0], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
